// File: rtl/imem_responder_pkg.sv
// Shared constants, state encoding and address-check helper for the
// instruction-memory responder.
package imem_responder_pkg;

   localparam int          INSTR_W           = 32;
   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_3000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // A fetch is bad if misaligned, below the window, or past the last word.
   function automatic logic addr_err(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth);
      logic [31:0] off;
      off = addr - base;
      return (addr[1:0] != 2'b00) || (addr < base) || ((off >> 2) >= depth);
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side request/response channel between the fetch stage (master)
// and the instruction-memory responder (slave).
interface imem_if;
   import imem_responder_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic [31:0]        req_addr;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [INSTR_W-1:0] rsp_data;
   logic [31:0]        rsp_pc;
   logic               rsp_err;
   logic               flush;

   modport master (
      output req_valid, req_addr, rsp_ready, flush,
      input  req_ready, rsp_valid, rsp_data, rsp_pc, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, flush,
      output req_ready, rsp_valid, rsp_data, rsp_pc, rsp_err
   );

endinterface

// File: rtl/imem_responder_array.sv
// Program storage: synchronous write through the load port, combinational
// read for the responder's capture path. Contents are never reset.
module imem_array
   import imem_responder_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we && (32'(waddr) < DEPTH)) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Reads beyond DEPTH only happen on fetches already flagged as errors.
   always_comb begin
      rdata = '0;
      if (32'(raddr) < DEPTH) begin
         rdata = mem_q[raddr];
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch at a time, with a
// configurable number of wait cycles before the registered response.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int          ADDR_W      = 12,
   parameter int          DEPTH       = 4096,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   imem_if.slave              bus,
   input  logic               load_we,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data
);

   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [31:0]        addr_q, addr_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [INSTR_W-1:0] rsp_data_q, rsp_data_d;
   logic [31:0]        rsp_pc_q, rsp_pc_d;
   logic               rsp_err_q, rsp_err_d;

   logic               accept;
   logic               start;
   logic               capture;
   logic [31:0]        cap_addr;
   logic [31:0]        cap_off;
   logic               cap_err;
   logic [ADDR_W-1:0]  rd_idx;
   logic [INSTR_W-1:0] rd_data;

   assign bus.req_ready = ~bus.flush & ((state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready));
   assign accept        = bus.req_valid & bus.req_ready;

   // With no wait cycles the capture happens on the accept edge itself.
   assign cap_addr = (WAIT_CYCLES == 0) ? bus.req_addr : addr_q;
   assign cap_off  = cap_addr - BASE_ADDR;
   assign rd_idx   = ADDR_W'(cap_off >> 2);
   assign cap_err  = addr_err(cap_addr, BASE_ADDR, DEPTH);

   imem_array #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (load_we),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (rd_idx),
      .rdata (rd_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_pc_d    = rsp_pc_q;
      rsp_err_d   = rsp_err_q;
      start       = 1'b0;
      capture     = 1'b0;

      if (bus.flush) begin
         state_d     = IDLE;
         cnt_d       = 4'd0;
         rsp_valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               start = accept;
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_d = RESP;
                  capture = 1'b1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state_d     = IDLE;
                  rsp_valid_d = 1'b0;
                  start       = accept;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      if (start) begin
         addr_d = bus.req_addr;
         if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            capture = 1'b1;
         end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
         end
      end

      // The array read is combinational, so a same-edge load is not yet visible.
      if (capture) begin
         rsp_valid_d = 1'b1;
         rsp_pc_d    = cap_addr;
         rsp_err_d   = cap_err;
         rsp_data_d  = cap_err ? '0 : rd_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_pc_q    <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_pc_q    <= rsp_pc_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_pc    = rsp_pc_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: one instance with one wait cycle
// (dut_a) and one with none (dut_b), sharing clock and reset.
module tb_imem_responder;
   import imem_responder_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        la_we, lb_we;
   logic [11:0] la_addr, lb_addr;
   logic [31:0] la_data, lb_data;

   exp_t qa[$];
   exp_t qb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   imem_if ia();
   imem_if ib();

   always #5 clk = ~clk;

   imem_responder #(.WAIT_CYCLES(1)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .bus       (ia),
      .load_we   (la_we),
      .load_addr (la_addr),
      .load_data (la_data)
   );

   imem_responder #(.WAIT_CYCLES(0)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .bus       (ib),
      .load_we   (lb_we),
      .load_addr (lb_addr),
      .load_data (lb_data)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitors: every completed response handshake is checked against the queue head.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (reset && ia.rsp_valid && ia.rsp_ready) begin
         if (qa.size() == 0) begin
            checkOutput("a_rsp_none_expected", 32'(ia.rsp_valid), 32'd0);
         end else begin
            e = qa.pop_front();
            checkOutput($sformatf("a_data_%h", e.pc), ia.rsp_data, e.data);
            checkOutput($sformatf("a_pc_%h", e.pc), ia.rsp_pc, e.pc);
            checkOutput($sformatf("a_err_%h", e.pc), 32'(ia.rsp_err), 32'(e.err));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (reset && ib.rsp_valid && ib.rsp_ready) begin
         if (qb.size() == 0) begin
            checkOutput("b_rsp_none_expected", 32'(ib.rsp_valid), 32'd0);
         end else begin
            e = qb.pop_front();
            checkOutput($sformatf("b_data_%h", e.pc), ib.rsp_data, e.data);
            checkOutput($sformatf("b_pc_%h", e.pc), ib.rsp_pc, e.pc);
            checkOutput($sformatf("b_err_%h", e.pc), 32'(ib.rsp_err), 32'(e.err));
         end
      end
   end

   task automatic loadWord(input int sel, input logic [11:0] idx, input logic [31:0] data);
      @(posedge clk); #1;
      if (sel == 1) begin
         lb_we = 1'b1; lb_addr = idx; lb_data = data;
      end else begin
         la_we = 1'b1; la_addr = idx; la_data = data;
      end
      @(posedge clk); #1;
      la_we = 1'b0;
      lb_we = 1'b0;
   endtask

   // Counts negedges after the accept edge until rsp_valid is seen.
   task automatic waitValid(input int sel, input int exp_lat, input string name);
      int lat;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if ((sel == 1) ? ib.rsp_valid : ia.rsp_valid) break;
      end
      checkOutput(name, 32'(lat), 32'(exp_lat));
   endtask

   task automatic applyStimulus(input int sel, input logic [31:0] addr, input logic [31:0] exp_data,
                                input logic exp_err, input int exp_lat);
      exp_t e;
      e.data = exp_data;
      e.pc   = addr;
      e.err  = exp_err;
      @(posedge clk); #1;
      if (sel == 1) begin
         ib.req_valid = 1'b1; ib.req_addr = addr; qb.push_back(e);
      end else begin
         ia.req_valid = 1'b1; ia.req_addr = addr; qa.push_back(e);
      end
      @(negedge clk);
      checkOutput($sformatf("req_ready_%0d_%h", sel, addr),
                  32'((sel == 1) ? ib.req_ready : ia.req_ready), 32'd1);
      @(posedge clk); #1;
      ia.req_valid = 1'b0;
      ib.req_valid = 1'b0;
      waitValid(sel, exp_lat, $sformatf("latency_%0d_%h", sel, addr));
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stim
      exp_t e;
      ia.req_valid = 1'b0; ia.req_addr = '0; ia.rsp_ready = 1'b1; ia.flush = 1'b0;
      ib.req_valid = 1'b0; ib.req_addr = '0; ib.rsp_ready = 1'b1; ib.flush = 1'b0;
      la_we = 1'b0; la_addr = '0; la_data = '0;
      lb_we = 1'b0; lb_addr = '0; lb_data = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_a_valid", 32'(ia.rsp_valid), 32'd0);
      checkOutput("rst_a_data", ia.rsp_data, 32'd0);
      checkOutput("rst_a_pc", ia.rsp_pc, 32'd0);
      checkOutput("rst_a_err", 32'(ia.rsp_err), 32'd0);
      checkOutput("rst_a_ready", 32'(ia.req_ready), 32'd1);
      checkOutput("rst_b_valid", 32'(ib.rsp_valid), 32'd0);
      checkOutput("rst_b_data", ib.rsp_data, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      loadWord(0, 12'd0, 32'h3C01_1234);
      loadWord(0, 12'd1, 32'h0051_3023);
      loadWord(0, 12'd4095, 32'hA5A5_5A5A);
      loadWord(1, 12'd3, 32'h1357_9BDF);

      $display("[TB] basic fetch");
      applyStimulus(0, 32'h0000_3000, 32'h3C01_1234, 1'b0, 2);

      $display("[TB] back-pressure and back-to-back accept");
      ia.rsp_ready = 1'b0;
      e.data = 32'h3C01_1234; e.pc = 32'h0000_3000; e.err = 1'b0;
      @(posedge clk); #1;
      ia.req_valid = 1'b1; ia.req_addr = 32'h0000_3000; qa.push_back(e);
      @(posedge clk); #1;
      ia.req_valid = 1'b0;
      waitValid(0, 2, "latency_bp");
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp_valid_%0d", i), 32'(ia.rsp_valid), 32'd1);
         checkOutput($sformatf("bp_data_%0d", i), ia.rsp_data, 32'h3C01_1234);
         checkOutput($sformatf("bp_pc_%0d", i), ia.rsp_pc, 32'h0000_3000);
         checkOutput($sformatf("bp_ready_%0d", i), 32'(ia.req_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      ia.rsp_ready = 1'b1;
      ia.req_valid = 1'b1; ia.req_addr = 32'h0000_3004;
      e.data = 32'h0051_3023; e.pc = 32'h0000_3004; e.err = 1'b0;
      qa.push_back(e);
      @(negedge clk);
      checkOutput("b2b_req_ready", 32'(ia.req_ready), 32'd1);
      @(posedge clk); #1;
      ia.req_valid = 1'b0;
      waitValid(0, 2, "latency_b2b");
      @(posedge clk); #1;

      $display("[TB] error and boundary fetches");
      applyStimulus(0, 32'h0000_3002, 32'h0, 1'b1, 2);
      applyStimulus(0, 32'h0000_2FFC, 32'h0, 1'b1, 2);
      applyStimulus(0, 32'h0000_7000, 32'h0, 1'b1, 2);
      applyStimulus(0, 32'h0000_6FFC, 32'hA5A5_5A5A, 1'b0, 2);

      $display("[TB] flush while waiting");
      ia.req_valid = 1'b1; ia.req_addr = 32'h0000_3008;
      @(posedge clk); #1;
      ia.flush = 1'b1; ia.req_addr = 32'h0000_3000;
      @(negedge clk);
      checkOutput("flush_req_ready", 32'(ia.req_ready), 32'd0);
      @(posedge clk); #1;
      ia.flush = 1'b0; ia.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("flush_valid_%0d", i), 32'(ia.rsp_valid), 32'd0);
      end
      checkOutput("flush_idle_ready", 32'(ia.req_ready), 32'd1);

      $display("[TB] zero-wait instance with same-edge load");
      e.data = 32'h1357_9BDF; e.pc = 32'h0000_300C; e.err = 1'b0;
      @(posedge clk); #1;
      ib.req_valid = 1'b1; ib.req_addr = 32'h0000_300C; qb.push_back(e);
      lb_we = 1'b1; lb_addr = 12'd3; lb_data = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      ib.req_valid = 1'b0; lb_we = 1'b0;
      waitValid(1, 1, "latency_b_300c");
      @(posedge clk); #1;
      applyStimulus(1, 32'h0000_300C, 32'hFFFF_FFFF, 1'b0, 1);
      applyStimulus(1, 32'h0000_3001, 32'h0, 1'b1, 1);

      $display("[TB] asynchronous reset while responding");
      ia.rsp_ready = 1'b0;
      @(posedge clk); #1;
      ia.req_valid = 1'b1; ia.req_addr = 32'h0000_3004;
      @(posedge clk); #1;
      ia.req_valid = 1'b0;
      waitValid(0, 2, "latency_pre_reset");
      checkOutput("pre_reset_data", ia.rsp_data, 32'h0051_3023);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(ia.rsp_valid), 32'd0);
      checkOutput("async_rst_data", ia.rsp_data, 32'd0);
      checkOutput("async_rst_err", 32'(ia.rsp_err), 32'd0);
      checkOutput("async_rst_pc", ia.rsp_pc, 32'd0);
      #1;
      reset = 1'b1;
      ia.rsp_ready = 1'b1;
      applyStimulus(0, 32'h0000_3000, 32'h3C01_1234, 1'b0, 2);

      repeat (2) @(posedge clk);
      checkOutput("qa_drained", 32'(qa.size()), 32'd0);
      checkOutput("qb_drained", 32'(qb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
